// File: rtl/wbs_pkg.sv
// Shared constants, FSM state encoding and sizing helpers for the wide-memory
// Wishbone bridge.
package wbs_pkg;

  localparam logic [31:0] WBS_BASE_ADDR   = 32'h3200_0000;
  localparam logic [31:0] WBS_REGION_MASK = 32'hFF00_0000;
  localparam int          WBS_DATA_W      = 32;

  typedef enum logic [1:0] {
    WBS_IDLE    = 2'd0,
    WBS_RD_REQ  = 2'd1,
    WBS_RD_WAIT = 2'd2,
    WBS_ACK     = 2'd3
  } wbs_state_e;

  function automatic int words_of(input int width);
    return (width + WBS_DATA_W - 1) / WBS_DATA_W;
  endfunction

  // Width of the word-select address field; kept at least one bit so that
  // single-word entries still have a legal (always-last) word index.
  function automatic int sel_bits(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/wbs_word_merge.sv
// Byte-masked merge of one 32-bit word into a MEM_WIDTH vector at a word index.
// Bits landing at or above MEM_WIDTH are dropped.
module wbs_word_merge
  import wbs_pkg::*;
#(
  parameter  int MEM_WIDTH = 64,
  localparam int NWORDS    = words_of(MEM_WIDTH),
  localparam int WSEL_W    = sel_bits(NWORDS)
) (
  input  logic [MEM_WIDTH-1:0] vec_i,
  input  logic [31:0]          word_i,
  input  logic [WSEL_W-1:0]    idx_i,
  input  logic [3:0]           sel_i,
  output logic [MEM_WIDTH-1:0] vec_o
);

  logic [NWORDS*32-1:0] pad;

  always_comb begin
    pad                  = '0;
    pad[MEM_WIDTH-1:0]   = vec_i;
    for (int w = 0; w < NWORDS; w++) begin
      if (int'(idx_i) == w) begin
        for (int b = 0; b < 4; b++) begin
          if (sel_i[b]) pad[w*32 + b*8 +: 8] = word_i[b*8 +: 8];
        end
      end
    end
  end

  assign vec_o = pad[MEM_WIDTH-1:0];

endmodule

// File: rtl/wbs_wide_mem_bridge.sv
// Wishbone slave giving 32-bit word access to banked MEM_WIDTH-bit SRAM entries.
// Define WBS_RDCACHE_EN to add a one-entry read cache.
module wbs_wide_mem_bridge
  import wbs_pkg::*;
#(
  parameter  int          MEM_WIDTH   = 64,
  parameter  int          MEM_DEPTH   = 64,
  parameter  int          NUM_BANKS   = 8,
  parameter  int          RD_LATENCY  = 1,
  parameter  logic [31:0] BASE_ADDR   = WBS_BASE_ADDR,
  parameter  logic [31:0] REGION_MASK = WBS_REGION_MASK,
  localparam int          NWORDS      = words_of(MEM_WIDTH),
  localparam int          WSEL_W      = sel_bits(NWORDS),
  localparam int          ADDR_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int          BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 wb_clk_i,
  input  logic                 rst_n,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NUM_BANKS-1:0] mem_csb0,
  output logic [NUM_BANKS-1:0] mem_web0,
  output logic [ADDR_W-1:0]    mem_addr0,
  output logic [MEM_WIDTH-1:0] mem_wdata0,
  input  logic [MEM_WIDTH-1:0] mem_rdata0 [NUM_BANKS],
  output logic [7:0]           oor_cnt_o
);

  localparam int          USED_W   = WSEL_W + BANK_W + ADDR_W;
  localparam logic [31:0] LOW_MASK = (USED_W >= 32) ? '1 : ((32'h1 << USED_W) - 32'h1);

  // ---- address decode ----
  logic [WSEL_W-1:0] a_word;
  logic [BANK_W-1:0] a_bank;
  logic [ADDR_W-1:0] a_entry;
  logic [31:0]       a_upper;
  logic              hit, oor, req;

  assign a_word  = wbs_adr_i[WSEL_W-1:0];
  assign a_bank  = wbs_adr_i[WSEL_W +: BANK_W];
  assign a_entry = wbs_adr_i[WSEL_W+BANK_W +: ADDR_W];
  assign a_upper = wbs_adr_i & ~REGION_MASK & ~LOW_MASK;
  assign hit     = (wbs_adr_i & REGION_MASK) == BASE_ADDR;
  assign oor     = (32'(a_entry) >= 32'(MEM_DEPTH)) || (32'(a_bank) >= 32'(NUM_BANKS))
                || (a_upper != 32'h0);
  // While ack is up the master still presents the finished request; ignore it.
  assign req     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;

  function automatic logic [31:0] pick(input logic [MEM_WIDTH-1:0] v,
                                       input logic [WSEL_W-1:0]    w);
    logic [NWORDS*32-1:0] p;
    p              = '0;
    p[MEM_WIDTH-1:0] = v;
    pick           = '0;
    for (int i = 0; i < NWORDS; i++) if (int'(w) == i) pick = p[i*32 +: 32];
  endfunction

  // ---- state ----
  wbs_state_e           state_q, state_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [NUM_BANKS-1:0] csb_q, csb_d, web_q, web_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [MEM_WIDTH-1:0] wdata_q, wdata_d, shadow_q, shadow_d;
  logic [7:0]           oor_q, oor_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [WSEL_W-1:0]    word_q, word_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [MEM_WIDTH-1:0] merged, rd_ent;

`ifdef WBS_RDCACHE_EN
  logic                 c_vld_q, c_vld_d;
  logic [BANK_W-1:0]    c_bank_q, c_bank_d;
  logic [ADDR_W-1:0]    c_entry_q, c_entry_d;
  logic [MEM_WIDTH-1:0] c_data_q, c_data_d;
  logic                 c_hit;
  assign c_hit = c_vld_q && (c_bank_q == a_bank) && (c_entry_q == a_entry);
`endif

  // One merge path serves both partial shadow updates and the full commit word.
  wbs_word_merge #(.MEM_WIDTH(MEM_WIDTH)) u_merge (
    .vec_i  (shadow_q),
    .word_i (wbs_dat_i),
    .idx_i  (a_word),
    .sel_i  (wbs_sel_i),
    .vec_o  (merged)
  );

  assign rd_ent = mem_rdata0[bank_q];

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    dat_d    = dat_q;
    csb_d    = '1;
    web_d    = '1;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    oor_d    = oor_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    bank_d   = bank_q;
`ifdef WBS_RDCACHE_EN
    c_vld_d   = c_vld_q;
    c_bank_d  = c_bank_q;
    c_entry_d = c_entry_q;
    c_data_d  = c_data_q;
`endif
    unique case (state_q)
      WBS_IDLE: if (req) begin
        word_d  = a_word;
        bank_d  = a_bank;
        state_d = WBS_ACK;
        if (oor) begin
          if (oor_q != 8'hFF) oor_d = oor_q + 8'd1;
          if (!wbs_we_i) dat_d = '0;
        end else if (wbs_we_i) begin
          shadow_d = merged;
          if (int'(a_word) == NWORDS - 1) begin
            csb_d[a_bank] = 1'b0;
            web_d[a_bank] = 1'b0;
            addr_d        = a_entry;
            wdata_d       = merged;
`ifdef WBS_RDCACHE_EN
            c_vld_d       = 1'b0;
`endif
          end
        end else begin
`ifdef WBS_RDCACHE_EN
          if (c_hit) begin
            dat_d = pick(c_data_q, a_word);
          end else begin
            csb_d[a_bank] = 1'b0;
            addr_d        = a_entry;
            state_d       = WBS_RD_REQ;
          end
`else
          csb_d[a_bank] = 1'b0;
          addr_d        = a_entry;
          state_d       = WBS_RD_REQ;
`endif
        end
      end
      WBS_RD_REQ, WBS_RD_WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = WBS_IDLE;
        end else if ((state_q == WBS_RD_REQ && RD_LATENCY <= 1) ||
                     (state_q == WBS_RD_WAIT && cnt_q == 2'(RD_LATENCY - 1))) begin
          dat_d   = pick(rd_ent, word_q);
          state_d = WBS_ACK;
`ifdef WBS_RDCACHE_EN
          c_vld_d   = 1'b1;
          c_bank_d  = bank_q;
          c_entry_d = addr_q;
          c_data_d  = rd_ent;
`endif
        end else if (state_q == WBS_RD_REQ) begin
          cnt_d   = 2'd1;
          state_d = WBS_RD_WAIT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WBS_ACK: begin
        ack_d   = 1'b1;
        state_d = WBS_IDLE;
      end
      default: state_d = WBS_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= WBS_IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      csb_q    <= '1;
      web_q    <= '1;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      oor_q    <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
      bank_q   <= '0;
`ifdef WBS_RDCACHE_EN
      c_vld_q   <= 1'b0;
      c_bank_q  <= '0;
      c_entry_q <= '0;
      c_data_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      oor_q    <= oor_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      bank_q   <= bank_d;
`ifdef WBS_RDCACHE_EN
      c_vld_q   <= c_vld_d;
      c_bank_q  <= c_bank_d;
      c_entry_q <= c_entry_d;
      c_data_q  <= c_data_d;
`endif
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign mem_csb0   = csb_q;
  assign mem_web0   = web_q;
  assign mem_addr0  = addr_q;
  assign mem_wdata0 = wdata_q;
  assign oor_cnt_o  = oor_q;

endmodule

// File: tb/tb_wbs_wide_mem_bridge.sv
// Directed bench for wbs_wide_mem_bridge at default parameters; expectations
// follow the WBS_RDCACHE_EN setting of the build.
module tb_wbs_wide_mem_bridge;

`ifdef WBS_RDCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic [7:0]  csb, web, oor;
  logic [5:0]  maddr;
  logic [63:0] mwdata;
  logic [63:0] rdata [8];

  always #5 clk = ~clk;

  wbs_wide_mem_bridge dut (
    .wb_clk_i   (clk),
    .rst_n      (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wdat),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .mem_csb0   (csb),
    .mem_web0   (web),
    .mem_addr0  (maddr),
    .mem_wdata0 (mwdata),
    .mem_rdata0 (rdata),
    .oor_cnt_o  (oor)
  );

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory-port monitor, sampled mid-cycle
  int         csb_cyc = 0;
  logic [7:0] m_csb, m_web;
  logic [5:0] m_addr;
  logic [63:0] m_wdata;
  always @(negedge clk) begin
    if (csb != 8'hFF) begin
      csb_cyc = csb_cyc + 1;
      m_csb   = csb;
      m_web   = web;
      m_addr  = maddr;
      m_wdata = mwdata;
    end
  end

  // lat = edge index (E0 = first sampling edge) at which ack was seen, -1 if none
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic [31:0] rd,
                      output logic ack_after);
    csb_cyc = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = -1; rd = '0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (ack) begin lat = n; rd = rdat; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    ack_after = ack;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        aa;
  int          acks;

  initial begin
    for (int i = 0; i < 8; i++) rdata[i] = '0;
    rdata[7] = 64'h1100_1010_DEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_csb", csb, 8'hFF);
    check("rst_web", web, 8'hFF);
    check("rst_addr", maddr, 0);
    check("rst_wdata", mwdata, 0);
    check("rst_oor", oor, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // read entry 1, bank 7
    xfer(32'h3200_001E, 1'b0, 0, 4'hF, lat, rd, aa);
    check("rd0_lat", lat, 2);
    check("rd0_dat", rd, 32'hDEAD_BEEF);
    check("rd0_csbcyc", csb_cyc, 1);
    check("rd0_csb", m_csb, 8'h7F);
    check("rd0_web", m_web, 8'hFF);
    check("rd0_addr", m_addr, 1);
    check("rd0_ack1cyc", aa, 0);
    xfer(32'h3200_001F, 1'b0, 0, 4'hF, lat, rd, aa);
    check("rd1_lat", lat, CACHE ? 1 : 2);
    check("rd1_dat", rd, 32'h1100_1010);
    check("rd1_csbcyc", csb_cyc, CACHE ? 0 : 1);

    // staged write: entry 3, bank 3
    xfer(32'h3200_0036, 1'b1, 32'h7654_3210, 4'hF, lat, rd, aa);
    check("wr0_lat", lat, 1);
    check("wr0_csbcyc", csb_cyc, 0);
    xfer(32'h3200_0037, 1'b1, 32'hFEDC_BA98, 4'hF, lat, rd, aa);
    check("wr1_lat", lat, 1);
    check("wr1_csbcyc", csb_cyc, 1);
    check("wr1_csb", m_csb, 8'hF7);
    check("wr1_web", m_web, 8'hF7);
    check("wr1_addr", m_addr, 3);
    check("wr1_wdata", m_wdata, 64'hFEDC_BA98_7654_3210);
    xfer(32'h3200_0037, 1'b1, 32'h0000_AAAA, 4'b0011, lat, rd, aa);
    check("wr2_csbcyc", csb_cyc, 1);
    check("wr2_wdata", m_wdata, 64'hFEDC_AAAA_7654_3210);

    // out of range, then outside the region
    xfer(32'h3200_0400, 1'b0, 0, 4'hF, lat, rd, aa);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_dat", rd, 0);
    check("oor_rd_csb", csb_cyc, 0);
    check("oor_cnt1", oor, 1);
    xfer(32'h3200_0400, 1'b1, 32'h1234_5678, 4'hF, lat, rd, aa);
    check("oor_wr_lat", lat, 1);
    check("oor_wr_csb", csb_cyc, 0);
    check("oor_cnt2", oor, 2);
    xfer(32'h3300_0000, 1'b0, 0, 4'hF, lat, rd, aa);
    check("nohit_lat", lat, -1);
    check("nohit_csb", csb_cyc, 0);

    // abort a read by dropping cyc in RD_REQ
    csb_cyc = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3200_001E; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (5) begin @(posedge clk); #1; if (ack) acks++; end
    check("abort_ack", acks, 0);
    check("abort_csb", csb_cyc, 1);
    xfer(32'h3200_001F, 1'b0, 0, 4'hF, lat, rd, aa);
    check("post_abort_lat", lat, 2);
    check("post_abort_dat", rd, 32'h1100_1010);

    // repeat read of the same entry, then commit to it and read again
    xfer(32'h3200_001E, 1'b0, 0, 4'hF, lat, rd, aa);
    check("rep_lat", lat, CACHE ? 1 : 2);
    check("rep_csb", csb_cyc, CACHE ? 0 : 1);
    check("rep_dat", rd, 32'hDEAD_BEEF);
    xfer(32'h3200_001F, 1'b1, 32'hFFFF_0000, 4'hF, lat, rd, aa);
    check("cw_wdata", m_wdata, 64'hFFFF_0000_7654_3210);
    check("cw_csb", m_csb, 8'h7F);
    xfer(32'h3200_001E, 1'b0, 0, 4'hF, lat, rd, aa);
    check("inv_lat", lat, 2);
    check("inv_csb", csb_cyc, 1);

    // saturation of the out-of-range counter
    for (int i = 0; i < 253; i++) xfer(32'h3200_0400, 1'b1, 0, 4'hF, lat, rd, aa);
    check("oor_255", oor, 255);
    xfer(32'h3200_0400, 1'b0, 0, 4'hF, lat, rd, aa);
    check("oor_sat", oor, 255);

    // reset in the middle of a read
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3200_001E; sel = 4'hF;
    @(posedge clk); #1;
    check("mid_csb_pre", csb, 8'h7F);
    rst_n = 1'b0;
    #1;
    check("mid_ack", ack, 0);
    check("mid_csb", csb, 8'hFF);
    check("mid_oor", oor, 0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
